reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
- Debug/readback engine that walks a contiguous address range of the register file through one read port.
- Streams each register's address and contents out on a valid/ready interface; the register file's write side is unaffected.
- Sits beside the register file, on the read-only side; used by the debug port and test benches to snapshot architectural state.

Parameters:
DATA_WIDTH, 8, register data width; must match the register file.
ADDR_WIDTH, 8, register address width; must match the register file.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a dump; ignored while busy=1
start_addr  input  ADDR_WIDTH  first address to read; sampled when start is accepted
end_addr  input  ADDR_WIDTH  last address to read, inclusive; sampled when start is accepted
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the final beat (including the checksum beat, if enabled) is accepted
rf_read_addr  output  ADDR_WIDTH  address driven to the register file read port
rf_read_data  input  DATA_WIDTH  combinational read data returned from the register file
out_valid  output  1  output beat valid
out_ready  input  1  consumer ready
out_addr  output  ADDR_WIDTH  register address of the current beat
out_data  output  DATA_WIDTH  register contents of the current beat
out_last  output  1  marks the final beat of the dump

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; busy, done, out_valid, out_last = 0.
  - out_addr, out_data, rf_read_addr, internal current/end address registers = 0.
- States: IDLE, READ, SEND, plus CSUM when the optional feature is compiled in.
- IDLE:
  - On start=1: latch cur=start_addr and end=end_addr, go to READ.
  - busy rises on the next cycle.
- READ (one cycle):
  - rf_read_addr=cur.
  - At the clock edge: capture out_data<=rf_read_data, out_addr<=cur, out_valid<=1, out_last<=(cur==end, and no checksum beat follows). Go to SEND.
- SEND:
  - out_valid, out_addr, out_data, out_last held stable until out_valid&&out_ready.
  - On handshake with cur!=end: cur<=cur+1 (mod 2^ADDR_WIDTH), out_valid<=0, go to READ.
  - On handshake with cur==end: go to CSUM if enabled; otherwise pulse done, clear busy/out_valid/out_last, go to IDLE.
- Throughput: 2 cycles per beat minimum (READ+SEND with out_ready held high). Latency from start to first out_valid is 2 cycles.
- rf_read_addr is driven with cur in every state after start; it is 0 in IDLE.
- Range and wrap-around:
  - Beat count = ((end_addr - start_addr) mod 2^ADDR_WIDTH) + 1.
  - start_addr==end_addr gives exactly one beat.
  - start_addr > end_addr wraps through 2^ADDR_WIDTH-1 to 0.
  - start_addr=0, end_addr=2^ADDR_WIDTH-1 dumps the full file.
- Concurrent register file writes:
  - Each register value is the one present at its READ cycle.
  - A write landing on the same edge is not observed; the pre-write value is captured.
- start while busy: ignored with no effect. start coincident with done: ignored, since state is not IDLE in that cycle.
- Back-pressure: out_ready low for any number of cycles stalls in SEND with no data change.
- Reset mid-dump: immediate abort, all outputs to reset values, no done pulse.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN.
- With the macro defined:
  - Running XOR of all dumped out_data values, cleared on start accept and updated at each data handshake.
  - After the last data beat, one extra CSUM beat: out_addr=0, out_data=XOR, out_last=1, out_valid=1, held until handshake. Then done pulses and the block returns to IDLE.
  - Data beats never assert out_last.
- Without the macro: no CSUM state or XOR register; the last data beat carries out_last=1.

Test Plan:
1. Preload regs 3..5 = 0x11,0x22,0x33; start with start_addr=3, end_addr=5, out_ready=1 -> beats (3,0x11),(4,0x22),(5,0x33), out_last on (5,0x33), done 6 cycles after start accept.
2. ADDR_WIDTH=8, start_addr=0xFE, end_addr=0x01 -> 4 beats, addresses FE,FF,00,01 in order.
3. Single register: start_addr=end_addr=7, reg7=0xA5 -> one beat (7,0xA5) with out_last=1; done pulses once.
4. Dump 2..4 with out_ready low for 5 cycles on each beat -> out_addr/out_data stable while stalled; no beat lost or duplicated; start pulses during the dump are ignored.
5. Assert rst while in SEND during a dump of 0..9 -> next cycle: busy=0, out_valid=0, outputs 0, no done pulse; a new start then dumps normally.
6. REG_DUMP_CHECKSUM_EN defined, regs 1..3 = 0x0F,0xF0,0x55 -> 3 data beats with out_last=0, then a CSUM beat (0,0xAA) with out_last=1, then done.

Source files
------------

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Debug readback engine. Walks an inclusive, wrapping address range of a
//   register file through its combinational read port and streams each
//   (address, data) pair out on a valid/ready channel.
//
//   Compile-time option: REG_DUMP_CHECKSUM_EN appends one trailing beat
//   (addr 0, data = XOR of every dumped word) that carries out_last.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             dump request, ignored while busy
//   start_addr        first address (sampled on accept)
//   end_addr          last address, inclusive (sampled on accept)
//   busy              dump in progress
//   done              one-cycle pulse when the final beat handshakes
//   rf_read_addr      register file read address (0 when idle)
//   rf_read_data      register file read data (combinational)
//   out_valid/ready   output handshake
//   out_addr/data     current beat payload
//   out_last          final beat marker
module reg_dump_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_READ, S_SEND} state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] end_q, end_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  logic hs;
  assign hs = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    valid_d = valid_q;
    last_d  = last_q;
    oaddr_d = oaddr_q;
    odata_d = odata_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          end_d   = end_addr;
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = S_READ;
        end
      end
      S_READ: begin
        odata_d = rf_read_data;
        oaddr_d = cur_q;
        valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
        last_d  = 1'b0;  // checksum beat always follows
`else
        last_d  = (cur_q == end_q);
`endif
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
`ifdef REG_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ odata_q;
`endif
          if (cur_q != end_q) begin
            cur_d   = cur_q + ADDR_WIDTH'(1);  // wraps through all-ones to 0
            valid_d = 1'b0;
            state_d = S_READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            oaddr_d = '0;
            odata_d = csum_q ^ odata_q;  // include the beat just accepted
            last_d  = 1'b1;
            valid_d = 1'b1;
            state_d = S_CSUM;
`else
            done    = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (hs) begin
          done    = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      end_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      oaddr_q <= '0;
      odata_q <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      oaddr_q <= oaddr_d;
      odata_q <= odata_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign rf_read_addr = (state_q == S_IDLE) ? '0 : cur_q;
  assign out_valid    = valid_q;
  assign out_last     = last_q;
  assign out_addr     = oaddr_q;
  assign out_data     = odata_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Randomized bench for reg_dump_reader. A register-file array feeds the read
// port; the reference model expands each dump request into the expected list
// of beats (wrapping address arithmetic, optional trailing XOR beat) and the
// monitor pops it on every handshake.
module tb_reg_dump_reader;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr, end_addr;
  logic          busy, done;
  logic [AW-1:0] rf_read_addr;
  logic [DW-1:0] rf_read_data;
  logic          out_valid, out_ready, out_last;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  logic [DW-1:0] regs [256];
  assign rf_read_data = regs[rf_read_addr];

  reg_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .busy(busy), .done(done),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat list for a dump of s..e (inclusive, modulo 2^AW).
  task automatic build_model(input logic [AW-1:0] s, input logic [AW-1:0] e);
    int n;
    logic [AW-1:0] a;
    logic [DW-1:0] x;
    beat_t b;
    exp_q.delete();
    n = int'(AW'(e - s)) + 1;
    x = '0;
    for (int i = 0; i < n; i++) begin
      a = AW'(int'(s) + i);
      b.addr = a;
      b.data = regs[a];
      x = x ^ regs[a];
`ifdef REG_DUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == n - 1);
`endif
      exp_q.push_back(b);
    end
`ifdef REG_DUMP_CHECKSUM_EN
    b.addr = '0;
    b.data = x;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // mode 0: ready held high; 1: random ready + stray starts;
  // 2: ready low 5 cycles per beat + stray starts.
  // Entered and left at posedge+1.
  task automatic run_dump(input logic [AW-1:0] s, input logic [AW-1:0] e, input int mode);
    int cyc, stall, limit;
    bit finished, prev_v, prev_hs;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic pl;
    beat_t b;
    build_model(s, e);
    limit = exp_q.size() * 16 + 20;
    start = 1'b1; start_addr = s; end_addr = e; out_ready = 1'b1;
    #1;
    chk("idle_busy", {31'b0, busy}, 0);
    chk("idle_rf_addr", {24'b0, rf_read_addr}, 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; stall = 0; finished = 0; prev_v = 0; prev_hs = 0;
    pa = '0; pd = '0; pl = 1'b0;
    while (!finished && cyc < limit) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && stall < 5) begin out_ready = 1'b0; stall++; end
          else out_ready = 1'b1;
        end
      endcase
      start = (mode != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      start_addr = AW'($urandom); end_addr = AW'($urandom);
      #1;
      chk("busy", {31'b0, busy}, 1);
      if (cyc == 0) chk("lat_read", {31'b0, out_valid}, 0);
      if (cyc == 1) chk("lat_first_valid", {31'b0, out_valid}, 1);
      if (!out_valid) chk("rf_read_addr", {24'b0, rf_read_addr}, {24'b0, exp_q[0].addr});
      if (prev_v && !prev_hs && out_valid) begin
        chk("stall_addr", {24'b0, out_addr}, {24'b0, pa});
        chk("stall_data", {24'b0, out_data}, {24'b0, pd});
        chk("stall_last", {31'b0, out_last}, {31'b0, pl});
      end
      prev_hs = out_valid && out_ready;
      if (prev_hs) begin
        b = exp_q.pop_front();
        chk("beat_addr", {24'b0, out_addr}, {24'b0, b.addr});
        chk("beat_data", {24'b0, out_data}, {24'b0, b.data});
        chk("beat_last", {31'b0, out_last}, {31'b0, b.last});
        chk("done", {31'b0, done}, {31'b0, exp_q.size() == 0});
        if (exp_q.size() == 0) finished = 1;
        stall = 0;
      end else begin
        chk("done_quiet", {31'b0, done}, 0);
      end
      prev_v = out_valid; pa = out_addr; pd = out_data; pl = out_last;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0; out_ready = 1'b1;
    if (!finished) chk("timeout_beats_left", exp_q.size(), 0);
    #1;
    chk("end_busy", {31'b0, busy}, 0);
    chk("end_valid", {31'b0, out_valid}, 0);
    chk("end_done", {31'b0, done}, 0);
    chk("end_rf_addr", {24'b0, rf_read_addr}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) regs[i] = DW'($urandom);
    rst = 1'b1; start = 1'b0; start_addr = '0; end_addr = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_last", {31'b0, out_last}, 0);
    chk("rst_addr", {24'b0, out_addr}, 0);
    chk("rst_data", {24'b0, out_data}, 0);
    chk("rst_rf_addr", {24'b0, rf_read_addr}, 0);
    chk("rst_done", {31'b0, done}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Small directed range
    regs[3] = 8'h11; regs[4] = 8'h22; regs[5] = 8'h33;
    run_dump(8'd3, 8'd5, 0);
    // Wrap through 0xFF
    run_dump(8'hFE, 8'h01, 0);
    // Single register
    regs[7] = 8'hA5;
    run_dump(8'd7, 8'd7, 0);
    // Back-pressure with stray starts
    run_dump(8'd2, 8'd4, 2);
    // Checksum pattern (plain range without the option)
    regs[1] = 8'h0F; regs[2] = 8'hF0; regs[3] = 8'h55;
    run_dump(8'd1, 8'd3, 0);

    // Reset while a beat is pending in SEND
    start = 1'b1; start_addr = 8'd0; end_addr = 8'd9; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 4 && !out_valid; i++) begin @(posedge clk); #1; end
    chk("pre_rst_valid", {31'b0, out_valid}, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_valid", {31'b0, out_valid}, 0);
    chk("abort_addr", {24'b0, out_addr}, 0);
    chk("abort_data", {24'b0, out_data}, 0);
    chk("abort_rf_addr", {24'b0, rf_read_addr}, 0);
    chk("abort_done", {31'b0, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'b0, busy}, 0);
    run_dump(8'd0, 8'd9, 0);

    // Random ranges, random ready
    for (int t = 0; t < 10; t++) begin
      logic [AW-1:0] s;
      s = AW'($urandom);
      run_dump(s, AW'(int'(s) + int'($urandom_range(0, 20))), int'($urandom_range(0, 2)));
    end
    // Full file
    run_dump(8'h00, 8'hFF, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
